reg_xfer_sequencer: RTL
=======================

# reg_xfer_sequencer

- Drives the CPU register file's select lines and bus inputs to perform whole register-transfer micro-operations.
- Supported operations: 8-bit move, 16-bit move, 16-bit increment/decrement, and 16-bit exchange through WZ.
- Sits between the opcode decoder and the register file, and owns all one-hot read/write select generation.

## Interface
Parameters:
- EXCH_TMP, 0, 16-bit code of the scratch pair used by EXCH16 (WZ).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Enable  in  1  tick enable; low freezes state and forces all selects to 0.
- i_Req_Valid  in  1  request strobe.
- o_Req_Ready  out  1  high only in IDLE with i_Enable high.
- i_Op  in  3  0 MOV8, 1 MOV16, 2 INC16, 3 DEC16, 4 EXCH16; 5–7 invalid.
- i_Src  in  3  source register code.
- i_Dst  in  3  destination register code.
- o_Read8  out  8  one-hot 8-bit read select (W,Z,B,C,D,E,H,L = bits 0–7).
- o_Write8  out  8  one-hot 8-bit write select.
- o_Bus8  out  8  data to the register file's 8-bit write bus.
- i_Bus8  in  8  register file 8-bit read data (combinational).
- o_Read16  out  6  one-hot 16-bit read select (WZ,BC,DE,HL,SP,PC = bits 0–5).
- o_Write16  out  6  one-hot 16-bit write select.
- o_Bus16  out  16  data to the register file's 16-bit write bus.
- i_Bus16  in  16  register file 16-bit read data (combinational).
- o_Done  out  1  one-cycle completion pulse.
- o_Err  out  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, S1, S2, S3, DONE.
- Accept: i_Req_Valid & o_Req_Ready at a rising edge latches Op/Src/Dst; the FSM goes to S1.
- Each step is one cycle. In that cycle the FSM asserts one read select, routes read data to the write bus, and asserts one write select.
- MOV8, step S1: o_Read8[Src], o_Bus8 = i_Bus8, o_Write8[Dst].
- MOV16, step S1: o_Read16[Src], o_Bus16 = i_Bus16, o_Write16[Dst].
- INC16 / DEC16, step S1: same as MOV16, but o_Bus16 = i_Bus16 ± 1, modulo 2^16.
  - 0xFFFF+1 = 0x0000; 0x0000−1 = 0xFFFF.
  - No flags are produced.
- EXCH16, three steps:
  - S1: Src → WZ.
  - S2: Dst → Src.
  - S3: WZ → Dst.
- After the last step the FSM goes to DONE (o_Done=1, ready low), then back to IDLE.
- Rejected requests: 8-bit code > 7 is impossible; 16-bit code > 5; Op ≥ 5; EXCH16 with Src or Dst = WZ. For these:
  - No selects are asserted.
  - The FSM goes to DONE with o_Err=1 and o_Done=0.
- At most one bit of each select vector is high at any time. Reads and writes of different widths are never asserted together.

## Timing
- Reset values: state IDLE, all selects 0, o_Bus8=0, o_Bus16=0, o_Done=0, o_Err=0, o_Req_Ready=1 (when i_Enable=1).
- Latency from the acceptance edge to the o_Done pulse:
  - MOV8, MOV16, INC16, DEC16: 2 cycles.
  - EXCH16: 4 cycles.
  - Error: 1 cycle.
- Next request: earliest acceptance is the edge after DONE.
- i_Enable low mid-operation: state is held; selects drop to 0 and resume unchanged when i_Enable returns.
- Reset asserted mid-EXCH16: selects clear immediately and the FSM goes to IDLE. Register contents written before the reset are kept (a partial exchange is permitted).
- Src == Dst: legal; the write-back occurs normally.
- All outputs are combinational from registered state plus i_Bus8/i_Bus16. There are no other combinational paths from request inputs.

## Configuration
- REG_XFER_EXCH_EN defined: EXCH16 is supported and S2/S3 exist.
- Not defined: Op 4 is treated as invalid (o_Err). The FSM has no S2/S3, and EXCH_TMP is unused.

## Structure
- Shared package holds:
  - Op-code constants.
  - 8-bit register codes (W..L = 0–7) and 16-bit codes (WZ..PC = 0–5).
  - State encoding.
  - The one-hot decode function.
- Sub-module idu16: combinational 16-bit increment/decrement (i_Data, i_Dec, o_Data). The future PC/SP incrementer reuses it.

## Test plan
- Reset: i_Rst=1 during MOV16 S1 → all selects 0 same cycle; o_Req_Ready=1 after release.
- MOV8 Src=2 (B=0x5A), Dst=7 → S1 shows o_Read8=0x04, o_Write8=0x80, o_Bus8=0x5A; o_Done at +2.
- INC16 Src=Dst=4 (SP=0xFFFF) → o_Bus16=0x0000, o_Write16=0x10. DEC16 on PC=0x0000 → 0xFFFF.
- EXCH16 BC=0x1234, DE=0xABCD → three steps with writes to WZ, BC, DE in that order; final state BC=0xABCD, DE=0x1234; o_Done at +4.
- Invalid: Op=MOV16 Src=6; and EXCH16 Src=0 → o_Err pulse at +1, no select asserted.
- i_Enable toggled low for 3 cycles between EXCH16 S1 and S2 → selects 0 while low; result is identical to the uninterrupted run.

Source files
------------

// File: rtl/reg_xfer_sequencer_pkg.sv
// Shared definitions for reg_xfer_sequencer: op codes, register codes, FSM states, one-hot decode.
// States S2/S3 exist only when REG_XFER_EXCH_EN is defined.
package reg_xfer_sequencer_pkg;

  localparam logic [2:0] OP_MOV8   = 3'd0;
  localparam logic [2:0] OP_MOV16  = 3'd1;
  localparam logic [2:0] OP_INC16  = 3'd2;
  localparam logic [2:0] OP_DEC16  = 3'd3;
  localparam logic [2:0] OP_EXCH16 = 3'd4;

  localparam logic [2:0] R8_W = 3'd0;
  localparam logic [2:0] R8_Z = 3'd1;
  localparam logic [2:0] R8_B = 3'd2;
  localparam logic [2:0] R8_C = 3'd3;
  localparam logic [2:0] R8_D = 3'd4;
  localparam logic [2:0] R8_E = 3'd5;
  localparam logic [2:0] R8_H = 3'd6;
  localparam logic [2:0] R8_L = 3'd7;

  localparam logic [2:0] R16_WZ = 3'd0;
  localparam logic [2:0] R16_BC = 3'd1;
  localparam logic [2:0] R16_DE = 3'd2;
  localparam logic [2:0] R16_HL = 3'd3;
  localparam logic [2:0] R16_SP = 3'd4;
  localparam logic [2:0] R16_PC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
`ifdef REG_XFER_EXCH_EN
    ST_S2,
    ST_S3,
`endif
    ST_DONE
  } state_t;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    onehot = 8'd1 << code;
  endfunction

endpackage

// File: rtl/reg_xfer_sequencer_idu16.sv
// Combinational 16-bit increment/decrement unit, wrapping modulo 2^16.
// Shared with the future PC/SP incrementer.
module idu16 (
  input  logic [15:0] i_Data,
  input  logic        i_Dec,
  output logic [15:0] o_Data
);

  assign o_Data = i_Dec ? (i_Data - 16'd1) : (i_Data + 16'd1);

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Register-transfer sequencer: turns one decoded request into one-hot register-file selects.
// Define REG_XFER_EXCH_EN to enable the three-step EXCH16 through the EXCH_TMP pair.
module reg_xfer_sequencer
  import reg_xfer_sequencer_pkg::*;
#(
  parameter logic [2:0] EXCH_TMP = R16_WZ
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic        i_Req_Valid,
  output logic        o_Req_Ready,
  input  logic [2:0]  i_Op,
  input  logic [2:0]  i_Src,
  input  logic [2:0]  i_Dst,
  output logic [7:0]  o_Read8,
  output logic [7:0]  o_Write8,
  output logic [7:0]  o_Bus8,
  input  logic [7:0]  i_Bus8,
  output logic [5:0]  o_Read16,
  output logic [5:0]  o_Write16,
  output logic [15:0] o_Bus16,
  input  logic [15:0] i_Bus16,
  output logic        o_Done,
  output logic        o_Err
);

  state_t      state;
  logic [2:0]  op_q;
  logic [2:0]  src_q;
  logic [2:0]  dst_q;
  logic        err_q;
  logic        req_bad;
  logic        step;
  logic        is8;
  logic        is_idu;
  logic [2:0]  rd_code;
  logic [2:0]  wr_code;
  logic [7:0]  rd_hot;
  logic [7:0]  wr_hot;
  logic [15:0] idu_out;

  always_comb begin
    req_bad = 1'b0;
    case (i_Op)
      OP_MOV8:                      req_bad = 1'b0;
      OP_MOV16, OP_INC16, OP_DEC16: req_bad = (i_Src > R16_PC) || (i_Dst > R16_PC);
`ifdef REG_XFER_EXCH_EN
      OP_EXCH16: req_bad = (i_Src > R16_PC) || (i_Dst > R16_PC) ||
                           (i_Src == EXCH_TMP) || (i_Dst == EXCH_TMP);
`endif
      default:                      req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      err_q <= 1'b0;
    end else if (i_Enable) begin
      case (state)
        ST_IDLE: if (i_Req_Valid) begin
          op_q  <= i_Op;
          src_q <= i_Src;
          dst_q <= i_Dst;
          err_q <= req_bad;
          state <= req_bad ? ST_DONE : ST_S1;
        end
`ifdef REG_XFER_EXCH_EN
        ST_S1:   state <= (op_q == OP_EXCH16) ? ST_S2 : ST_DONE;
        ST_S2:   state <= ST_S3;
        ST_S3:   state <= ST_DONE;
`else
        ST_S1:   state <= ST_DONE;
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Exchange routing: S1 src->tmp, S2 dst->src, S3 tmp->dst.
  always_comb begin
    rd_code = src_q;
    wr_code = dst_q;
    case (state)
      ST_S1: wr_code = (op_q == OP_EXCH16) ? EXCH_TMP : dst_q;
`ifdef REG_XFER_EXCH_EN
      ST_S2: begin
        rd_code = dst_q;
        wr_code = src_q;
      end
      ST_S3: rd_code = EXCH_TMP;
`endif
      default: ;
    endcase
  end

`ifdef REG_XFER_EXCH_EN
  assign step = i_Enable && (state == ST_S1 || state == ST_S2 || state == ST_S3);
`else
  assign step = i_Enable && (state == ST_S1);
`endif

  assign is8    = (op_q == OP_MOV8);
  assign is_idu = (op_q == OP_INC16) || (op_q == OP_DEC16);
  assign rd_hot = onehot(rd_code);
  assign wr_hot = onehot(wr_code);

  idu16 u_idu (
    .i_Data (i_Bus16),
    .i_Dec  (op_q == OP_DEC16),
    .o_Data (idu_out)
  );

  assign o_Read8     = (step && is8)  ? rd_hot      : '0;
  assign o_Write8    = (step && is8)  ? wr_hot      : '0;
  assign o_Bus8      = (step && is8)  ? i_Bus8      : '0;
  assign o_Read16    = (step && !is8) ? rd_hot[5:0] : '0;
  assign o_Write16   = (step && !is8) ? wr_hot[5:0] : '0;
  assign o_Bus16     = (step && !is8) ? (is_idu ? idu_out : i_Bus16) : '0;
  assign o_Done      = i_Enable && (state == ST_DONE) && !err_q;
  assign o_Err       = i_Enable && (state == ST_DONE) && err_q;
  assign o_Req_Ready = i_Enable && (state == ST_IDLE);

endmodule
